// File: rtl/mem_pkg.sv
// Shared types and constants for the dual-port memory responder.
package mem_pkg;

  localparam int WORD_SIZE = 16;
  localparam int CNT_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } port_state_e;

endpackage

// File: rtl/dual_port_mem_responder_if.sv
// Request/ready handshake of the instruction and data ports; the data buses
// are bidirectional and stay plain ports on the responder.
interface dual_port_mem_responder_if;
  import mem_pkg::*;

  logic                 i_readM;
  logic                 i_writeM;
  logic [WORD_SIZE-1:0] i_address;
  logic                 i_ready;

  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic                 d_ready;

  modport master (
    output i_readM, i_writeM, i_address,
    output d_readM, d_writeM, d_address,
    input  i_ready, d_ready
  );

  modport slave (
    input  i_readM, i_writeM, i_address,
    input  d_readM, d_writeM, d_address,
    output i_ready, d_ready
  );

endinterface

// File: rtl/mem_port_fsm.sv
// One memory port: accepts a held request, counts down a fixed latency and
// raises ready for one cycle; holds the address/data captured at accept.
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int LATENCY = 2  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic                 i_wr,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic                 o_ready,
  output logic                 o_wr,
  output logic [WORD_SIZE-1:0] o_addr,
  output logic [WORD_SIZE-1:0] o_wdata
);

  port_state_e          r_state;
  port_state_e          w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_accept;
  logic                 r_wr;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_wr    <= i_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        // Completion wins over a late drop: ready is already visible.
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else if (!i_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_ready = (r_state == BUSY) && (r_cnt == '0);
  assign o_wr    = r_wr;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/dual_port_mem_responder.sv
// Instruction and data port responder over one shared word array.
// Optional: DMEM_WRITE_FORWARD_EN forwards a same-cycle D-write to an I-read.
module dual_port_mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH = 256,  // power of two
  parameter int LATENCY   = 2     // 1..15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  dual_port_mem_responder_if.slave  bus,
  inout  wire  [WORD_SIZE-1:0]      i_data,
  inout  wire  [WORD_SIZE-1:0]      d_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [WORD_SIZE-1:0] r_mem [MEM_DEPTH];

  logic                 w_i_ready;
  logic [WORD_SIZE-1:0] w_i_addr;
  logic                 w_unused_i_wr;
  logic [WORD_SIZE-1:0] w_unused_i_wdata;
  logic                 w_d_ready;
  logic                 w_d_wr;
  logic [WORD_SIZE-1:0] w_d_addr;
  logic [WORD_SIZE-1:0] w_d_wdata;
  logic                 w_d_req;
  logic                 w_d_commit;
  logic [IDX_W-1:0]     w_i_idx;
  logic [IDX_W-1:0]     w_d_idx;
  logic [WORD_SIZE-1:0] w_i_word;
  logic                 w_unused;

  mem_port_fsm #(.LATENCY(LATENCY)) u_i_port (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (bus.i_readM),
    .i_wr    (1'b0),
    .i_addr  (bus.i_address),
    .i_wdata ('0),
    .o_ready (w_i_ready),
    .o_wr    (w_unused_i_wr),
    .o_addr  (w_i_addr),
    .o_wdata (w_unused_i_wdata)
  );

  // A combined read+write request is a write.
  assign w_d_req = bus.d_readM | bus.d_writeM;

  mem_port_fsm #(.LATENCY(LATENCY)) u_d_port (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (w_d_req),
    .i_wr    (bus.d_writeM),
    .i_addr  (bus.d_address),
    .i_wdata (d_data),
    .o_ready (w_d_ready),
    .o_wr    (w_d_wr),
    .o_addr  (w_d_addr),
    .o_wdata (w_d_wdata)
  );

  // Word index is the address modulo the depth; upper address bits drop.
  assign w_i_idx = w_i_addr[IDX_W-1:0];
  assign w_d_idx = w_d_addr[IDX_W-1:0];

  // A reset landing on the completion edge aborts the write.
  assign w_d_commit = w_d_ready && w_d_wr && reset_n;

  // NOTE: the array is deliberately not reset; contents survive reset and
  // the storage can map onto plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (w_d_commit) begin
      r_mem[w_d_idx] <= w_d_wdata;
    end
  end

`ifdef DMEM_WRITE_FORWARD_EN
  assign w_i_word = (w_d_commit && (w_d_idx == w_i_idx)) ? w_d_wdata : r_mem[w_i_idx];
`else
  assign w_i_word = r_mem[w_i_idx];
`endif

  assign i_data = (bus.i_readM && w_i_ready) ? w_i_word : 'z;
  assign d_data = (bus.d_readM && !bus.d_writeM && w_d_ready) ? r_mem[w_d_idx] : 'z;

  assign bus.i_ready = w_i_ready;
  assign bus.d_ready = w_d_ready;

  assign w_unused = &{1'b0, bus.i_writeM, w_unused_i_wr, w_unused_i_wdata,
                      w_i_addr[WORD_SIZE-1:IDX_W], w_d_addr[WORD_SIZE-1:IDX_W]};

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench: directed cases plus randomized traffic against a
// transaction-level model of the shared array.
module tb_dual_port_mem_responder;
  import mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;
`ifdef DMEM_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r_drive;
  logic [15:0] r_wdata;
  wire  [15:0] i_data;
  wire  [15:0] d_data;

  logic [15:0] model_mem [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  assign d_data = r_drive ? r_wdata : 'z;

  dual_port_mem_responder_if bus ();

  dual_port_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .i_data  (i_data),
    .d_data  (d_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  // An undriven bus reads as Z in four-state tools and as zero in two-state.
  function automatic logic is_idle(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic i_op(input logic [15:0] addr, input int reps, input logic [15:0] exp_first);
    int n;
    logic [15:0] exp;
    bus.i_readM   = 1'b1;
    bus.i_writeM  = 1'($urandom);
    bus.i_address = addr;
    for (int r = 0; r < reps; r++) begin
      exp = (r == 0) ? exp_first : model_mem[idx(addr)];
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!bus.i_ready) begin
          check("i_bus_idle", is_idle(i_data), 1'b1);
          if (n == ((r == 0) ? 1 : 2)) bus.i_address = 16'($urandom);
        end
      end while (!bus.i_ready && n < 20);
      check("i_latency", n, (r == 0) ? LAT : LAT + 1);
      check("i_rdata", i_data, exp);
      bus.i_address = addr;
    end
    bus.i_readM  = 1'b0;
    bus.i_writeM = 1'b0;
    @(negedge clk);
    check("i_ready_pulse", bus.i_ready, 1'b0);
    check("i_bus_after", is_idle(i_data), 1'b1);
  endtask

  task automatic d_op(input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input int reps);
    int n;
    logic [15:0] exp;
    bus.d_readM   = rd;
    bus.d_writeM  = wr;
    bus.d_address = addr;
    r_wdata       = wdata;
    r_drive       = wr;
    for (int r = 0; r < reps; r++) begin
      exp = model_mem[idx(addr)];
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!bus.d_ready) begin
          if (!wr) check("d_bus_idle", is_idle(d_data), 1'b1);
          if (n == ((r == 0) ? 1 : 2)) begin
            bus.d_address = 16'($urandom);
            r_wdata       = 16'($urandom) | 16'h1;
          end
        end
      end while (!bus.d_ready && n < 20);
      check("d_latency", n, (r == 0) ? LAT : LAT + 1);
      if (wr) model_mem[idx(addr)] = wdata;
      else    check("d_rdata", d_data, exp);
      bus.d_address = addr;
      r_wdata       = wdata;
    end
    bus.d_readM  = 1'b0;
    bus.d_writeM = 1'b0;
    r_drive      = 1'b0;
    @(negedge clk);
    check("d_ready_pulse", bus.d_ready, 1'b0);
  endtask

  // Write request dropped one cycle after accept: must never complete.
  task automatic d_abort(input logic [15:0] addr, input logic [15:0] wdata);
    bus.d_writeM  = 1'b1;
    bus.d_address = addr;
    r_wdata       = wdata;
    r_drive       = 1'b1;
    @(negedge clk);
    check("abort_busy_ready", bus.d_ready, 1'b0);
    bus.d_writeM = 1'b0;
    r_drive      = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_ready", bus.d_ready, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] ai, ad, w, ei, v;
    int op;

    reset_n       = 1'b0;
    bus.i_readM   = 1'b1;
    bus.i_writeM  = 1'b1;
    bus.i_address = 16'h0010;
    bus.d_readM   = 1'b1;
    bus.d_writeM  = 1'b1;
    bus.d_address = 16'h0010;
    r_wdata       = 16'hFFFF;
    r_drive       = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v = 16'($urandom) | 16'h1;
      dut.r_mem[i] = v;
      model_mem[i] = v;
    end

    repeat (2) begin
      @(negedge clk);
      check("rst_i_ready", bus.i_ready, 1'b0);
      check("rst_d_ready", bus.d_ready, 1'b0);
      check("rst_i_bus", is_idle(i_data), 1'b1);
    end
    bus.i_readM  = 1'b0;
    bus.i_writeM = 1'b0;
    bus.d_readM  = 1'b0;
    bus.d_writeM = 1'b0;
    r_drive      = 1'b0;
    reset_n      = 1'b1;
    @(negedge clk);

    dut.r_mem[8'h10] = 16'hBEEF;
    model_mem[8'h10] = 16'hBEEF;
    i_op(16'h0010, 1, 16'hBEEF);

    d_op(1'b0, 1'b1, 16'h0020, 16'h1234, 1);
    d_op(1'b1, 1'b0, 16'h0020, 16'h0000, 2);

    d_abort(16'h0020, 16'h9999);
    d_op(1'b1, 1'b0, 16'h0020, 16'h0000, 1);
    check("abort_kept_word", model_mem[8'h20], 16'h1234);

    d_op(1'b0, 1'b1, 16'h0105, 16'hAAAA, 1);
    i_op(16'h0005, 1, 16'hAAAA);

    dut.r_mem[8'h30] = 16'h1111;
    model_mem[8'h30] = 16'h1111;
    fork
      i_op(16'h0030, 1, FWD ? 16'h2222 : 16'h1111);
      d_op(1'b0, 1'b1, 16'h0030, 16'h2222, 1);
    join
    i_op(16'h0030, 1, 16'h2222);

    // Reset arriving in the completion cycle must discard the write.
    bus.d_writeM  = 1'b1;
    bus.d_address = 16'h0040;
    r_wdata       = 16'h5A5A;
    r_drive       = 1'b1;
    repeat (LAT) @(negedge clk);
    check("rst_mid_ready", bus.d_ready, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    bus.d_writeM = 1'b0;
    r_drive      = 1'b0;
    check("rst_mid_abort", bus.d_ready, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    i_op(16'h0040, 1, model_mem[8'h40]);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      ai = 16'($urandom);
      w  = 16'($urandom) | 16'h1;
      case (op)
        0: i_op(ai, $urandom_range(1, 2), model_mem[idx(ai)]);
        1: d_op(1'b1, 1'b0, ai, 16'h0000, $urandom_range(1, 2));
        2: d_op(1'($urandom), 1'b1, ai, w, $urandom_range(1, 2));
        3: d_abort(ai, w);
        default: begin
          ad = ($urandom_range(0, 1) == 1) ? {8'($urandom), ai[7:0]} : 16'($urandom);
          ei = (idx(ai) == idx(ad) && FWD) ? w : model_mem[idx(ai)];
          fork
            i_op(ai, 1, ei);
            d_op(1'($urandom), 1'b1, ad, w, 1);
          join
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_port_mem_responder.md
# dual_port_mem_responder

Responder end of the CPU's two memory interfaces: services the instruction-fetch port (`i_*`) and the data port (`d_*`) against one shared word array. Each port accepts a held request, waits a fixed latency, pulses a per-port ready, and drives read data onto that port's bidirectional bus. It sits beside the CPU in the top-level testbench/system and replaces the zero-latency behavioural memory, so the datapath's stall logic can be exercised.

## Interface
- `WORD_SIZE`, 16: data and address width.
- `MEM_DEPTH`, 256: words in the array; power of two.
- `LATENCY`, 2: cycles from accept to ready; legal range 1..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `i_readM`  in  1  instruction read request, held until `i_ready`.
- `i_writeM`  in  1  ignored.
- `i_address`  in  WORD_SIZE  instruction word address.
- `i_data`  inout  WORD_SIZE  driven by block only while `i_readM && i_ready`, else high-Z.
- `i_ready`  out  1  instruction access complete (one-cycle pulse).
- `d_readM`  in  1  data read request, held until `d_ready`.
- `d_writeM`  in  1  data write request, held until `d_ready`.
- `d_address`  in  WORD_SIZE  data word address.
- `d_data`  inout  WORD_SIZE  write data from CPU; driven by block only while `d_readM && !d_writeM && d_ready`, else high-Z.
- `d_ready`  out  1  data access complete (one-cycle pulse).

## Operation
- Each port: FSM `IDLE`, `BUSY`; down-counter `cnt` (4 bits).
- `IDLE`: request high at edge -> accept: capture address (and for writes, `d_data`), `cnt <= LATENCY-1`, go `BUSY`.
- `BUSY`: `cnt != 0` -> decrement. `cnt == 0` -> `ready` high (combinational from state/cnt); at that edge commit write (data port), go `IDLE`.
- Request dropped while `BUSY` -> return `IDLE` at next edge; `ready` not asserted, no write committed.
- Address/data changes while `BUSY` ignored; captured values used.
- `d_readM && d_writeM` together -> treated as write.
- Index = captured address modulo `MEM_DEPTH` (low log2(MEM_DEPTH) bits); high bits silently discarded.
- Read data = array[captured index] sampled during ready cycle.
- I-read ready and D-write ready in same cycle, same index -> I-read returns old word (array written at end of that cycle), unless forwarding enabled.
- Array contents not affected by reset; bench preloads via hierarchical write.

## Timing
- Reset: both FSMs `IDLE`, `cnt` 0, `i_ready` 0, `d_ready` 0, both buses high-Z. Reset mid-access aborts it; no write committed.
- Accept edge E -> ready high in cycle after edge E+LATENCY-1 (LATENCY=1: cycle immediately after accept).
- Ready high exactly one cycle; write lands at edge ending that cycle.
- Request still high after ready -> re-accepted at next edge (from `IDLE`); back-to-back period LATENCY+1 cycles.
- Ports fully independent; simultaneous accepts allowed.

## Configuration
- `DMEM_WRITE_FORWARD_EN` defined: I-read completing in same cycle as D-write to same index returns the write data.
- Undefined: returns pre-write array word (as above).

## Structure
- Package `mem_pkg`: `WORD_SIZE`, FSM state typedef (`IDLE`/`BUSY`), latency counter width.
- Sub-module `mem_port_fsm` (request, ready, cnt, capture registers), instantiated twice; array, bus tri-states, forwarding mux in top.

## Test plan
- Reset held 2 cycles, all requests high -> `i_ready`/`d_ready` 0, buses high-Z throughout.
- LATENCY=2, preload [0x10]=0xBEEF, `i_readM` at addr 0x10 -> `i_ready` one cycle, 2 cycles after accept, `i_data`=0xBEEF that cycle only.
- `d_writeM` addr 0x20 data 0x1234, then `d_readM` addr 0x20 -> read returns 0x1234; request held -> second ready at period 3.
- `d_writeM` started, dropped after 1 cycle -> no `d_ready`, [0x20] unchanged.
- MEM_DEPTH=256, `d_writeM` addr 0x0105 data 0xAAAA -> [0x05]=0xAAAA.
- Aligned I-read and D-write to 0x30 (old 0x1111, new 0x2222) -> `i_data`=0x1111 without macro, 0x2222 with `DMEM_WRITE_FORWARD_EN`.
